// File: rtl/div_seq_32x16.sv
// div_seq_32x16: sequential restoring divider, 2N-bit / N-bit -> N-bit quotient and remainder, one bit per clock.
// Define DIV_OVF_CHECK_EN to flag divide-by-zero/overflow and return in one cycle.
module div_seq_32x16 #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           done,
  output logic           ovf,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [2*N:0]  acu_q, acu_d, s;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, ovf_c, unused_msb;
  logic [N+1:0]  t;
`ifdef DIV_OVF_CHECK_EN
  assign ovf_c = divisor == '0 || dividend[2*N-1:N] >= divisor;
`else
  assign ovf_c = 1'b0;
`endif
  assign s = {acu_q[2*N-1:0], 1'b0};
  // t[N+1] is the borrow of the trial subtraction
  assign t = {1'b0, s[2*N:N]} - {2'b00, dvs_q};
  assign unused_msb = acu_q[2*N];
  always_comb begin
    state_d = state_q;
    acu_d   = acu_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && st) begin
      state_d = ovf_c ? DONE : RUN;
      acu_d   = ovf_c ? {{(N+1){1'b0}}, {N{1'b1}}} : {1'b0, dividend};
      dvs_d   = ovf_c ? dvs_q : divisor;
      cnt_d   = ovf_c ? cnt_q : '0;
      ovf_d   = ovf_c;
    end else if (state_q == RUN) begin
      acu_d   = t[N+1] ? s : {t[N:0], s[N-1:1], 1'b1};
      cnt_d   = cnt_q + CW'(1);
      state_d = cnt_q == CW'(N-1) ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acu_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acu_q   <= acu_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
  assign done      = state_q == DONE;
  assign ovf       = ovf_q;
  assign quotient  = acu_q[N-1:0];
  assign remainder = acu_q[2*N-1:N];
endmodule

// File: tb/tb_div_seq_32x16.sv
// tb_div_seq_32x16: randomized self-checking bench against an arithmetic reference (/ and %).
module tb_div_seq_32x16;
  localparam int N = 16;
  logic clk = 0, rst = 1, st = 0;
  logic [31:0] dividend = 0;
  logic [15:0] divisor = 0;
  logic done, ovf;
  logic [15:0] quotient, remainder;
  int tests = 0, fails = 0, cyc_cnt = 0;

  div_seq_32x16 #(.N(N)) dut (
    .clk(clk), .rst(rst), .st(st), .dividend(dividend), .divisor(divisor),
    .done(done), .ovf(ovf), .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic ovf_ref(input logic [31:0] dd, input logic [15:0] ds);
`ifdef DIV_OVF_CHECK_EN
    return ds == 0 || dd[31:16] >= ds;
`else
    return 1'b0;
`endif
  endfunction

  task automatic rand_pair(output logic [31:0] dd, output logic [15:0] ds);
    logic [15:0] q, r;
    ds = 16'($urandom_range(1, 16'hFFFF));
    q  = 16'($urandom);
    r  = 16'($urandom_range(0, int'(ds) - 1));
    dd = 32'(q) * 32'(ds) + 32'(r);
  endtask

  // Starts an operation from IDLE and reports the done cycle index (1 = cycle after acceptance)
  task automatic do_op(input logic [31:0] dd, input logic [15:0] ds, output int lat,
                       output logic [15:0] q, output logic [15:0] r, output logic o);
    repeat (2) @(negedge clk);
    dividend = dd; divisor = ds; st = 1;
    @(posedge clk); #1 st = 0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1 lat++;
    end
    q = quotient; r = remainder; o = ovf;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({done, ovf, quotient, remainder} !== 34'd0) begin
      fails++; $display("FAIL reset: done=%b ovf=%b q=%h r=%h, want all 0", done, ovf, quotient, remainder);
    end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_directed;
    int lat; logic [15:0] q, r; logic o;
    do_op(32'd100, 16'd7, lat, q, r, o);
    tests++;
    if (lat !== N + 1 || q !== 16'd14 || r !== 16'd2 || o !== 1'b0) begin
      fails++; $display("FAIL 100/7: lat=%0d q=%0d r=%0d ovf=%b, want 17 14 2 0", lat, q, r, o);
    end
    do_op(32'hFFFE0001, 16'hFFFF, lat, q, r, o);
    tests++;
    if (lat !== N + 1 || q !== 16'hFFFF || r !== 16'h0 || o !== 1'b0) begin
      fails++; $display("FAIL max: lat=%0d q=%h r=%h ovf=%b, want 17 ffff 0000 0", lat, q, r, o);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL done_pulse: done=%b one cycle after done, want 0", done);
    end
  endtask

  task automatic test_random;
    int lat; logic [15:0] q, r, ds; logic o; logic [31:0] dd;
    for (int i = 0; i < 20; i++) begin
      rand_pair(dd, ds);
      do_op(dd, ds, lat, q, r, o);
      tests++;
      if (lat !== N + 1 || q !== 16'(dd / 32'(ds)) || r !== 16'(dd % 32'(ds)) || o !== 1'b0) begin
        fails++; $display("FAIL random %h/%h: lat=%0d q=%h r=%h ovf=%b, want 17 %h %h 0",
                          dd, ds, lat, q, r, o, 16'(dd / 32'(ds)), 16'(dd % 32'(ds)));
      end
    end
  endtask

  task automatic test_ovf;
    int lat; logic [15:0] q, r; logic o;
    logic [31:0] dds [2] = '{32'h12345678, 32'h00070000};
    logic [15:0] dss [2] = '{16'd0, 16'd7};
    for (int i = 0; i < 2; i++) begin
      do_op(dds[i], dss[i], lat, q, r, o);
      if (ovf_ref(dds[i], dss[i])) begin
        tests++;
        if (lat !== 1 || q !== 16'hFFFF || r !== 16'h0 || o !== 1'b1) begin
          fails++; $display("FAIL ovf%0d: lat=%0d q=%h r=%h ovf=%b, want 1 ffff 0000 1", i, lat, q, r, o);
        end
      end else begin
        tests++;
        if (lat !== N + 1 || o !== 1'b0) begin
          fails++; $display("FAIL noovf%0d: lat=%0d ovf=%b, want 17 0", i, lat, o);
        end
      end
    end
  endtask

  task automatic test_st_ignored;
    int lat, extra;
    repeat (2) @(negedge clk);
    dividend = 32'd100; divisor = 16'd7; st = 1;
    @(posedge clk); #1 st = 0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 5) begin
        dividend = 32'd5000; divisor = 16'd3; st = 1;
      end else st = 0;
      @(posedge clk); #1 lat++;
    end
    st = 0;
    tests++;
    if (lat !== N + 1 || quotient !== 16'd14 || remainder !== 16'd2) begin
      fails++; $display("FAIL st_ignored: lat=%0d q=%0d r=%0d, want 17 14 2", lat, quotient, remainder);
    end
    extra = 0;
    repeat (25) begin
      @(posedge clk); #1 if (done) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++; $display("FAIL extra_done: %0d extra done pulses, want 0", extra);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, seen; logic [15:0] q, r; logic o;
    repeat (2) @(negedge clk);
    dividend = 32'd100; divisor = 16'd7; st = 1;
    @(posedge clk); #1 st = 0;
    seen = 0;
    for (int c = 1; c < 8; c++) begin
      @(posedge clk); #1 if (done) seen++;
    end
    rst = 1;
    @(posedge clk); #1;
    tests++;
    if (seen !== 0 || {done, ovf, quotient, remainder} !== 34'd0) begin
      fails++; $display("FAIL mid_reset: seen=%0d done=%b ovf=%b q=%h r=%h, want 0", seen, done, ovf, quotient, remainder);
    end
    rst = 0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1 if (done) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL abort_done: %0d done pulses after abort, want 0", seen);
    end
    do_op(32'd123456, 16'd789, lat, q, r, o);
    tests++;
    if (lat !== N + 1 || q !== 16'd156 || r !== 16'd372 || o !== 1'b0) begin
      fails++; $display("FAIL post_reset: lat=%0d q=%0d r=%0d ovf=%b, want 17 156 372 0", lat, q, r, o);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] dd; logic [15:0] ds; int wait_c, t_prev, t_now;
    repeat (2) @(negedge clk);
    rand_pair(dd, ds);
    dividend = dd; divisor = ds; st = 1;
    t_prev = 0;
    for (int i = 0; i < 1000; i++) begin
      wait_c = 0;
      @(posedge clk); #1;
      while (!done && wait_c < 40) begin
        @(posedge clk); #1 wait_c++;
      end
      t_now = cyc_cnt;
      tests++;
      if (!done || (i > 0 && t_now - t_prev !== N + 2) ||
          32'(quotient) * 32'(ds) + 32'(remainder) !== dd || remainder >= ds) begin
        fails++; $display("FAIL b2b%0d: done=%b gap=%0d q=%h r=%h for %h/%h, want gap 18 q=%h r=%h",
                          i, done, t_now - t_prev, quotient, remainder, dd, ds,
                          16'(dd / 32'(ds)), 16'(dd % 32'(ds)));
      end
      t_prev = t_now;
      rand_pair(dd, ds);
      dividend = dd; divisor = ds;
    end
    st = 0;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ovf;
    test_st_ignored;
    test_reset_mid_run;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
